// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
//   WIDTH          operand width (results are 2*WIDTH as a hi/lo pair)
//   op_t           operation encodings issued by the control unit
//   state_t        sequencer states
//   DIV0_QUOTIENT  quotient returned when the divisor is zero
//   is_div_op / is_signed_op  decode helpers for op_t
package mult_div_unit_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result interface between the control unit and mult_div_unit.
//   start, op, op_a, op_b                : issue side (driven by master)
//   busy, done, result_lo, result_hi,
//   div_by_zero                          : status/result side (driven by slave)
interface mult_div_unit_if #(
    parameter int WIDTH = mult_div_unit_pkg::WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    modport master (
        output start, op, op_a, op_b,
        input  busy, done, result_lo, result_hi, div_by_zero
    );

    modport slave (
        input  start, op, op_a, op_b,
        output busy, done, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply/divide unit (one bit per cycle).
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mult_div_unit_if.slave
//          start/op/op_a/op_b in; busy/done/result_lo/result_hi/div_by_zero out
// Operands are converted to magnitudes on issue, iterated for WIDTH cycles
// (shift-add multiply or restoring divide), then sign-corrected in FIX.
// Every output is a register.
module mult_div_unit #(
    parameter int WIDTH = mult_div_unit_pkg::WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    import mult_div_unit_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_t             state_reg;
    op_t                op_reg;
    logic [CW-1:0]      count_reg;
    logic               sa_reg;
    logic               sb_reg;
    // Multiply: multiplicand magnitude. Divide: dividend shifts out of the
    // top while quotient bits shift in at the bottom, so it ends as quotient.
    logic [WIDTH-1:0]   a_reg;
    // Multiply: multiplier, consumed LSB-first. Divide: divisor magnitude.
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   rem_reg;

    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   result_lo_reg;
    logic [WIDTH-1:0]   result_hi_reg;
    logic               div_by_zero_reg;

    // Issue-side decode
    op_t                in_op;
    logic               in_signed;
    logic               in_sa;
    logic               in_sb;
    logic [WIDTH-1:0]   in_mag_a;
    logic [WIDTH-1:0]   in_mag_b;
    logic               in_div_zero;

    // Iteration datapath
    logic [2*WIDTH-1:0] mul_addend;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic               q_bit;

    // Sign correction
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        in_op     = op_t'(bus.op);
        in_signed = is_signed_op(in_op);
        in_sa     = in_signed & bus.op_a[WIDTH-1];
        in_sb     = in_signed & bus.op_b[WIDTH-1];
        // Negating the most-negative value wraps back to itself, which is
        // exactly its unsigned magnitude.
        in_mag_a  = in_sa ? -bus.op_a : bus.op_a;
        in_mag_b  = in_sb ? -bus.op_b : bus.op_b;
        in_div_zero = is_div_op(in_op) && (bus.op_b == '0);
    end

    always_comb begin
        mul_addend = {{WIDTH{1'b0}}, a_reg} << count_reg;
        acc_next   = b_reg[0] ? (acc_reg + mul_addend) : acc_reg;

        // 17-bit trial value: previous remainder shifted left with the next
        // dividend bit. When the subtract succeeds the true difference is
        // below the divisor, so its low WIDTH bits are the whole answer.
        rem_shift  = {rem_reg, a_reg[WIDTH-1]};
        q_bit      = (rem_shift >= {1'b0, b_reg});
        rem_diff   = rem_shift[WIDTH-1:0] - b_reg;
    end

    // sa/sb are only ever set for signed ops, so unsigned results pass through.
    always_comb begin
        prod_fix = (sa_reg ^ sb_reg) ? -acc_reg : acc_reg;
        quo_fix  = (sa_reg ^ sb_reg) ? -a_reg : a_reg;
        rem_fix  = sa_reg ? -rem_reg : rem_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            op_reg          <= OP_MUL;
            count_reg       <= '0;
            sa_reg          <= 1'b0;
            sb_reg          <= 1'b0;
            a_reg           <= '0;
            b_reg           <= '0;
            acc_reg         <= '0;
            rem_reg         <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            result_lo_reg   <= '0;
            result_hi_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (bus.start) begin
                        busy_reg <= 1'b1;
                        if (in_div_zero) begin
                            // Skip iteration entirely; results are known now.
                            result_lo_reg   <= DIV0_QUOTIENT;
                            result_hi_reg   <= bus.op_a;
                            div_by_zero_reg <= 1'b1;
                            done_reg        <= 1'b1;
                            state_reg       <= DONE;
                        end else begin
                            op_reg    <= in_op;
                            sa_reg    <= in_sa;
                            sb_reg    <= in_sb;
                            a_reg     <= in_mag_a;
                            b_reg     <= in_mag_b;
                            acc_reg   <= '0;
                            rem_reg   <= '0;
                            count_reg <= '0;
                            state_reg <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (is_div_op(op_reg)) begin
                        rem_reg <= q_bit ? rem_diff : rem_shift[WIDTH-1:0];
                        a_reg   <= {a_reg[WIDTH-2:0], q_bit};
                    end else begin
                        acc_reg <= acc_next;
                        b_reg   <= b_reg >> 1;
                    end
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(WIDTH - 1)) begin
                        state_reg <= FIX;
                    end
                end

                FIX: begin
                    if (is_div_op(op_reg)) begin
                        result_lo_reg <= quo_fix;
                        result_hi_reg <= rem_fix;
                    end else begin
                        result_lo_reg <= prod_fix[WIDTH-1:0];
                        result_hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    div_by_zero_reg <= 1'b0;
                    done_reg        <= 1'b1;
                    state_reg       <= DONE;
                end

                DONE: begin
                    // start is deliberately not looked at here.
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.result_lo   = result_lo_reg;
    assign bus.result_hi   = result_hi_reg;
    assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: a table of operations with
// hand-computed results, plus restart-while-busy and mid-operation reset.
module tb_mult_div_unit;

    localparam logic [1:0] MUL  = 2'b00;
    localparam logic [1:0] MULU = 2'b01;
    localparam logic [1:0] DIV  = 2'b10;
    localparam logic [1:0] DIVU = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mult_div_unit_if #(.WIDTH(16)) bif ();

    mult_div_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to done. restart_at > 0 raises start
    // again (with a divide-by-zero request) during that cycle of the run.
    task automatic run_op(input vec_t v, input int restart_at);
        int cycles;
        int busy_low;
        bit seen;
        int exp_lat;
        exp_lat = v.exp_dbz ? 1 : 18;
        @(negedge clk);
        bif.op    = v.op;
        bif.op_a  = v.a;
        bif.op_b  = v.b;
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        // Operands are free to change once the start edge has passed.
        bif.start = 1'b0;
        bif.op    = DIV;
        bif.op_a  = ~v.a;
        bif.op_b  = 16'h0000;
        cycles   = 0;
        busy_low = 0;
        seen     = 0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            bif.start = (restart_at != 0 && cycles == restart_at);
            if (!bif.busy) busy_low++;
            if (bif.done) seen = 1;
        end
        bif.start = 1'b0;
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b cycles=%0d",
                 v.name, v.op, v.a, v.b, bif.result_hi, bif.result_lo, bif.div_by_zero, cycles);
        check({v.name, " done_seen"}, 32'(seen), 32'd1);
        check({v.name, " latency"}, 32'(cycles), 32'(exp_lat));
        check({v.name, " busy_low_cycles"}, 32'(busy_low), 32'd0);
        check({v.name, " result_hi"}, {16'h0, bif.result_hi}, {16'h0, v.exp_hi});
        check({v.name, " result_lo"}, {16'h0, bif.result_lo}, {16'h0, v.exp_lo});
        check({v.name, " div_by_zero"}, 32'(bif.div_by_zero), 32'(v.exp_dbz));
        @(negedge clk);
        check({v.name, " done_pulse_end"}, 32'(bif.done), 32'd0);
        check({v.name, " busy_end"}, 32'(bif.busy), 32'd0);
        check({v.name, " hold"}, {bif.result_hi, bif.result_lo}, {v.exp_hi, v.exp_lo});
    endtask

    vec_t vecs [10];

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"mulu_basic",  MULU, 16'h0F00, 16'h0050, 16'h0004, 16'hB000, 1'b0};
        vecs[1] = '{"mul_neg",     MUL,  16'hFFFF, 16'h0002, 16'hFFFF, 16'hFFFE, 1'b0};
        vecs[2] = '{"mulu_ffff",   MULU, 16'hFFFF, 16'h0002, 16'h0001, 16'hFFFE, 1'b0};
        vecs[3] = '{"divu_basic",  DIVU, 16'h0040, 16'h0024, 16'h001C, 16'h0001, 1'b0};
        vecs[4] = '{"div_negdvd",  DIV,  16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
        vecs[5] = '{"div_zero",    DIV,  16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
        vecs[6] = '{"mul_minneg",  MUL,  16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
        vecs[7] = '{"div_ovf",     DIV,  16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
        vecs[8] = '{"divu_zero",   DIVU, 16'hABCD, 16'h0000, 16'hABCD, 16'hFFFF, 1'b1};
        vecs[9] = '{"div_negdvsr", DIV,  16'h0064, 16'hFFF9, 16'h0002, 16'hFFF2, 1'b0};

        rst      = 1'b0;
        bif.start = 1'b0;
        bif.op    = MUL;
        bif.op_a  = 16'h0000;
        bif.op_b  = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bif.busy), 32'd0);
        check("reset done", 32'(bif.done), 32'd0);
        check("reset results", {bif.result_hi, bif.result_lo}, 32'h0);
        check("reset dbz", 32'(bif.div_by_zero), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], 0);
        end

        // Extra: negative dividend by positive divisor, remainder follows dividend.
        v = '{"div_rem_neg", DIV, 16'hFF9C, 16'h0007, 16'hFFFE, 16'hFFF2, 1'b0};
        run_op(v, 0);

        // start re-asserted during RUN iteration 5 must be ignored.
        v = '{"restart_ignored", MULU, 16'h0F00, 16'h0050, 16'h0004, 16'hB000, 1'b0};
        run_op(v, 5);

        // Reset in the middle of an operation.
        @(negedge clk);
        bif.op    = MULU;
        bif.op_a  = 16'h1111;
        bif.op_b  = 16'h0003;
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        repeat (8) @(negedge clk);
        check("midrun busy_before_rst", 32'(bif.busy), 32'd1);
        rst = 1'b0;
        #1;
        $display("txn mid_reset busy=%b done=%b hi=%h lo=%h dbz=%b",
                 bif.busy, bif.done, bif.result_hi, bif.result_lo, bif.div_by_zero);
        check("midrun rst busy", 32'(bif.busy), 32'd0);
        check("midrun rst done", 32'(bif.done), 32'd0);
        check("midrun rst results", {bif.result_hi, bif.result_lo}, 32'h0);
        check("midrun rst dbz", 32'(bif.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("after rst idle", 32'(bif.busy), 32'd0);

        v = '{"mulu_after_rst", MULU, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0};
        run_op(v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
